issue_ctrl: RTL and testbench

//  Issue scheduler for the decode stage. Holds a per-register scoreboard, counts in-flight

---
 rtl/issue_ctrl.sv | 89 ++++++++
 tb/tb_issue_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-stage issue scheduler with register scoreboard, in-flight limit and branch flush.
// Optional ISSUE_WB_BYPASS_EN: a register written back this cycle counts as free for the hazard check.
module issue_ctrl #(
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid_i,
    input  logic            rs1_read_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic            rs2_read_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [4:0]      wd_i,
    input  logic            is_branch_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic            retire_i,
    input  logic            br_resolve_i,
    input  logic            br_taken_i,
    output logic            id_en_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic [NREG-1:0] busy_o
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_e;

    state_e          state_q;
    logic [NREG-1:0] busy_q, busy_d, wb_clr, set_mask, chk_busy;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [FW-1:0]   fcnt_q;
    logic            id_en_q, flush_q, hazard, issue;

    always_comb begin
        wb_clr = (wb_we_i && wb_addr_i != 5'd0) ? (NREG'(1) << wb_addr_i) : '0;
`ifdef ISSUE_WB_BYPASS_EN
        chk_busy = busy_q & ~wb_clr;
`else
        chk_busy = busy_q;
`endif
        hazard = (rs1_read_i & chk_busy[rs1_addr_i]) |
                 (rs2_read_i & chk_busy[rs2_addr_i]) |
                 ((wd_i != 5'd0) & chk_busy[wd_i]);
        // The full check uses the registered count, so a same-cycle retire never frees a slot.
        issue = inst_valid_i & (state_q == RUN) & ~hazard & (inflight_q < CW'(MAX_INFLIGHT));
        set_mask = (issue && wd_i != 5'd0) ? (NREG'(1) << wd_i) : '0;
        busy_d = ((busy_q & ~wb_clr) | set_mask) & ~NREG'(1);
        inflight_d = inflight_q + CW'(issue) - CW'(retire_i && inflight_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            busy_q     <= '0;
            inflight_q <= '0;
            fcnt_q     <= '0;
            id_en_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            id_en_q    <= issue;
            case (state_q)
                RUN: if (issue && is_branch_i) state_q <= BR_WAIT;
                BR_WAIT: if (br_resolve_i) begin
                    state_q <= br_taken_i ? FLUSH : RUN;
                    flush_q <= br_taken_i;
                    fcnt_q  <= FW'(FLUSH_CYCLES - 1);
                end
                FLUSH: if (fcnt_q == '0) begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                end else begin
                    fcnt_q <= fcnt_q - FW'(1);
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign id_en_o = id_en_q;
    assign flush_o = flush_q;
    assign busy_o  = busy_q;
    assign stall_o = inst_valid_i & ~issue;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vector table plus hand-written reset/flush sequences for issue_ctrl.
module tb_issue_ctrl;
`ifdef ISSUE_WB_BYPASS_EN
    localparam logic B = 1'b1;
`else
    localparam logic B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, inst_valid, rs1_read, rs2_read, is_branch, wb_we, retire, br_resolve, br_taken;
    logic [4:0]  rs1_addr, rs2_addr, wd, wb_addr;
    logic        id_en, stall, flush;
    logic [31:0] busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        string      nm;
        logic       rs, v, r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2, wd;
        logic       br, we;
        logic [4:0] wa;
        logic       ret, res, tk;
        logic       st, ide, fl;
        logic [31:0] bz;
    } vec_t;

    vec_t tbl[$];

    issue_ctrl dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid),
        .rs1_read_i(rs1_read), .rs1_addr_i(rs1_addr),
        .rs2_read_i(rs2_read), .rs2_addr_i(rs2_addr),
        .wd_i(wd), .is_branch_i(is_branch), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
        .retire_i(retire), .br_resolve_i(br_resolve), .br_taken_i(br_taken),
        .id_en_o(id_en), .stall_o(stall), .flush_o(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rs; inst_valid = t.v; rs1_read = t.r1; rs1_addr = t.a1;
        rs2_read = t.r2; rs2_addr = t.a2; wd = t.wd; is_branch = t.br;
        wb_we = t.we; wb_addr = t.wa; retire = t.ret; br_resolve = t.res; br_taken = t.tk;
    endtask

    task automatic step(input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        chk({t.nm, "/stall"}, 32'(stall), 32'(t.st));
        chk({t.nm, "/id_en"}, 32'(id_en), 32'(t.ide));
        chk({t.nm, "/flush"}, 32'(flush), 32'(t.fl));
        chk({t.nm, "/busy"},  busy, t.bz);
    endtask

    initial begin
        int fl_len;
        vec_t idle;
        idle = vec_t'{"idle", 0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0};
        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //                  nm             rs v  r1 a1 r2 a2 wd br we wa ret res tk   st  ide fl  busy
        tbl.push_back(vec_t'{"t1_issue",    0,1, 0,0, 0,0, 5, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t2_haz_rs1",  0,1, 1,5, 0,0, 0, 0, 0,0, 0,0,0,     1,  1,  0, 32'h20});
        tbl.push_back(vec_t'{"t2_haz_rs2",  0,1, 0,0, 1,5, 0, 0, 0,0, 0,0,0,     1,  0,  0, 32'h20});
        tbl.push_back(vec_t'{"t2_wb",       0,1, 1,5, 0,0, 0, 0, 1,5, 0,0,0,    ~B,  0,  0, 32'h20});
        tbl.push_back(vec_t'{"t2_after",    0,~B,1,5, 0,0, 0, 0, 0,0, 0,0,0,     0,  B,  0, 32'h0});
        tbl.push_back(vec_t'{"t2_idle",     0,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0, ~B,  0, 32'h0});
        tbl.push_back(vec_t'{"ret_wb0",     0,0, 0,0, 0,0, 0, 0, 1,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"ret_1",       0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"ret_at0",     0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_i0",       0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_i1",       0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_i2",       0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_i3",       0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_full",     0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     1,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_ret_nofr", 0,1, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     1,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_refill",   0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_full2",    0,1, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     1,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_iss_ret",  0,1, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_fill",     0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t3_full3",    0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     1,  1,  0, 32'h0});
        for (int i = 0; i < 4; i++)
            tbl.push_back(vec_t'{"t3_drain", 0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_br",       0,1, 0,0, 0,0, 0, 1, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_wait",     0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     1,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_taken",    0,1, 0,0, 0,0, 0, 0, 0,0, 0,1,1,     1,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_fl1",      0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     1,  0,  1, 32'h0});
        tbl.push_back(vec_t'{"t4_fl2",      0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     1,  0,  1, 32'h0});
        tbl.push_back(vec_t'{"t4_resume",   0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_br2",      0,1, 0,0, 0,0, 0, 1, 0,0, 0,0,0,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_ntaken",   0,1, 0,0, 0,0, 0, 0, 0,0, 0,1,0,     1,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_run",      0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_res_ign",  0,0, 0,0, 0,0, 0, 0, 0,0, 1,1,1,     0,  1,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_no_flush", 0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_drain",    0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t4_drain",    0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t5_set_clr",  0,1, 0,0, 0,0, 7, 0, 1,7, 0,0,0,     0,  0,  0, 32'h0});
        tbl.push_back(vec_t'{"t5_set_win",  0,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  1,  0, 32'h80});
        tbl.push_back(vec_t'{"t5_wd_haz",   0,1, 0,0, 0,0, 7, 0, 1,7, 0,0,0,    ~B,  0,  0, 32'h80});
        tbl.push_back(vec_t'{"t5_chk",      0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  B,  0, B ? 32'h80 : 32'h0});
        tbl.push_back(vec_t'{"t5_ret",      0,0, 0,0, 0,0, 0, 0, 0,0, 1,0,0,     0,  0,  0, B ? 32'h80 : 32'h0});
        tbl.push_back(vec_t'{"t5_clr",      0,0, 0,0, 0,0, 0, 0, 1,7, 0,0,0,     0,  0,  0, B ? 32'h80 : 32'h0});
        tbl.push_back(vec_t'{"t5_zero",     0,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,     0,  0,  0, 32'h0});
        foreach (tbl[i]) step(tbl[i]);

        // Reset while waiting on a branch, then while flushing.
        step(vec_t'{"r6_br",    0,1, 0,0, 0,0, 9, 1, 0,0, 0,0,0,  0, 0, 0, 32'h0});
        step(vec_t'{"r6_rst_bw",1,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  1, 1, 0, 32'h200});
        step(vec_t'{"r6_post1", 0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  0, 0, 0, 32'h0});
        step(vec_t'{"r6_br2",   0,1, 0,0, 0,0, 0, 1, 0,0, 0,0,0,  0, 1, 0, 32'h0});
        step(vec_t'{"r6_taken", 0,0, 0,0, 0,0, 0, 0, 0,0, 0,1,1,  0, 1, 0, 32'h0});
        step(vec_t'{"r6_rst_fl",1,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  0, 0, 1, 32'h0});
        step(vec_t'{"r6_post2", 0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  0, 0, 0, 32'h0});
        step(vec_t'{"r6_idle",  0,0, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  0, 1, 0, 32'h0});

        // Flush pulse length measured over a bounded window.
        step(vec_t'{"fl_br",    0,1, 0,0, 0,0, 0, 1, 0,0, 0,0,0,  0, 0, 0, 32'h0});
        step(vec_t'{"fl_taken", 0,0, 0,0, 0,0, 0, 0, 0,0, 0,1,1,  0, 1, 0, 32'h0});
        fl_len = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(idle);
            #1;
            if (flush === 1'b1) fl_len++;
        end
        chk("flush_len", 32'(fl_len), 32'd2);
        step(vec_t'{"fl_done",  0,1, 0,0, 0,0, 0, 0, 0,0, 0,0,0,  0, 0, 0, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
